pwm_control: RTL and testbench

PWM_CONTROL -- requirements
Module: pwm_control

---
 rtl/pwm_pkg.sv | 32 +++
 rtl/pwm_control_debounce.sv | 93 +++++++++
 rtl/pwm_control.sv | 69 ++++++
 tb/tb_pwm_control.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg -- shared constants and duty arithmetic for the PWM controller.
//   PERIOD_DEF/STEP_DEF/DEBOUNCE_DEF : default timing at 50 MHz
//   REPEAT_*_DEF                     : auto-repeat timing (HOLD_REPEAT_EN builds)
//   DUTY_W / CALC_W                  : duty output width / internal arithmetic width
//   DISP_STEP                        : one percent of the default period, for the display
package pwm_pkg;

  localparam int unsigned PERIOD_DEF       = 500_000;
  localparam int unsigned STEP_DEF         = 25_000;
  localparam int unsigned DEBOUNCE_DEF     = 1_000_000;
  localparam int unsigned REPEAT_FIRST_DEF = 25_000_000;
  localparam int unsigned REPEAT_NEXT_DEF  = 12_500_000;
  localparam int unsigned DISP_STEP        = 5_000;

  localparam int DUTY_W = 19;
  localparam int CALC_W = 20;

  typedef logic [CALC_W-1:0] calc_t;

  // One extra bit over the duty width keeps pend+step from wrapping before the clamp.
  function automatic calc_t duty_next(input calc_t pend, input logic up, input logic dn,
                                      input calc_t step, input calc_t period);
    calc_t sum;
    sum       = pend + step;
    duty_next = pend;
    if (up && !dn)
      duty_next = (sum > period) ? period : sum;
    else if (dn && !up)
      duty_next = (pend < step) ? '0 : pend - step;
  endfunction

endpackage

// File: rtl/pwm_control_debounce.sv
// pwm_control_debounce -- one push-button front end: 2-flop synchronizer,
// debounce counter, single-cycle press pulse and (HOLD_REPEAT_EN) hold auto-repeat.
//   clk, rst_n : system clock, async active-low reset
//   btn        : raw asynchronous button, active high
//   event_p    : one-cycle pulse per accepted press (and per repeat when enabled)
module pwm_control_debounce
  import pwm_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
`ifdef HOLD_REPEAT_EN
  , parameter int unsigned REPEAT_FIRST = REPEAT_FIRST_DEF
  , parameter int unsigned REPEAT_NEXT  = REPEAT_NEXT_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic event_p
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic [1:0]      sync_q;
  logic [1:0]      vld_q;
  logic            acc_q;
  logic            arm_q;
  logic [DB_W-1:0] cnt_q;
  logic            lvl;
  logic            accept;
  logic            press;

  assign lvl    = sync_q[1];
  assign accept = (lvl != acc_q) && (cnt_q == DB_W'(DEBOUNCE - 1));
  // Presses only count once a settled low has been seen since reset, so a
  // button held through reset release must be let go before it does anything.
  assign press  = accept && lvl && arm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      vld_q  <= '0;
      acc_q  <= 1'b0;
      arm_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      vld_q  <= {vld_q[0], 1'b1};
      if (lvl == acc_q)
        cnt_q <= '0;
      else if (accept) begin
        cnt_q <= '0;
        acc_q <= lvl;
      end else
        cnt_q <= cnt_q + DB_W'(1);
      // vld_q[1] marks the synchronizer as holding a real sample, not its reset zero
      if (vld_q[1] && !lvl && !acc_q)
        arm_q <= 1'b1;
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam int unsigned RP_MAX = (REPEAT_FIRST > REPEAT_NEXT) ? REPEAT_FIRST : REPEAT_NEXT;
  localparam int          RP_W   = $clog2(RP_MAX + 1);

  logic            rep_run_q;
  logic [RP_W-1:0] rep_cnt_q;
  logic            rep_evt;

  assign rep_evt = rep_run_q && acc_q && (rep_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_run_q <= 1'b0;
      rep_cnt_q <= '0;
    end else if (press) begin
      rep_run_q <= 1'b1;
      rep_cnt_q <= RP_W'(REPEAT_FIRST - 1);
    end else if (!acc_q)
      rep_run_q <= 1'b0;
    else if (rep_run_q) begin
      if (rep_cnt_q == '0)
        rep_cnt_q <= RP_W'(REPEAT_NEXT - 1);
      else
        rep_cnt_q <= rep_cnt_q - RP_W'(1);
    end
  end

  assign event_p = press || rep_evt;
`else
  assign event_p = press;
`endif

endmodule

// File: rtl/pwm_control.sv
// pwm_control -- button-adjusted PWM generator.
//   CLK, RST_N : system clock, async active-low reset
//   BTN_UP/DN  : raw buttons, +STEP / -STEP duty per press (saturating)
//   PWM_OUT    : registered PWM waveform, high while count < active duty
//   PWM        : active duty (high-time count), updates only at period wrap
// Optional: define HOLD_REPEAT_EN for auto-repeat while a button is held.
module pwm_control
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD   = PERIOD_DEF,
  parameter int unsigned STEP     = STEP_DEF,
  parameter int unsigned DEBOUNCE = DEBOUNCE_DEF
`ifdef HOLD_REPEAT_EN
  , parameter int unsigned REPEAT_FIRST = REPEAT_FIRST_DEF
  , parameter int unsigned REPEAT_NEXT  = REPEAT_NEXT_DEF
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              BTN_UP,
  input  logic              BTN_DN,
  output logic              PWM_OUT,
  output logic [DUTY_W-1:0] PWM
);

  localparam int    CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam calc_t PERIOD_C = calc_t'(PERIOD);
  localparam calc_t STEP_C   = calc_t'(STEP);

  logic              up_evt;
  logic              dn_evt;
  logic [CNT_W-1:0]  cnt_q;
  calc_t             pend_q;
  logic [DUTY_W-1:0] act_q;
  logic              wrap;

`ifdef HOLD_REPEAT_EN
  pwm_control_debounce #(.DEBOUNCE(DEBOUNCE), .REPEAT_FIRST(REPEAT_FIRST), .REPEAT_NEXT(REPEAT_NEXT))
    u_db_up (.clk(CLK), .rst_n(RST_N), .btn(BTN_UP), .event_p(up_evt));
  pwm_control_debounce #(.DEBOUNCE(DEBOUNCE), .REPEAT_FIRST(REPEAT_FIRST), .REPEAT_NEXT(REPEAT_NEXT))
    u_db_dn (.clk(CLK), .rst_n(RST_N), .btn(BTN_DN), .event_p(dn_evt));
`else
  pwm_control_debounce #(.DEBOUNCE(DEBOUNCE))
    u_db_up (.clk(CLK), .rst_n(RST_N), .btn(BTN_UP), .event_p(up_evt));
  pwm_control_debounce #(.DEBOUNCE(DEBOUNCE))
    u_db_dn (.clk(CLK), .rst_n(RST_N), .btn(BTN_DN), .event_p(dn_evt));
`endif

  assign wrap = (cnt_q == CNT_W'(PERIOD - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      pend_q  <= '0;
      act_q   <= '0;
      PWM_OUT <= 1'b0;
    end else begin
      cnt_q   <= wrap ? '0 : cnt_q + CNT_W'(1);
      // Loading on the last count means the new duty governs the whole next period.
      if (wrap)
        act_q <= pend_q[DUTY_W-1:0];
      pend_q  <= duty_next(pend_q, up_evt, dn_evt, STEP_C, PERIOD_C);
      PWM_OUT <= calc_t'(cnt_q) < calc_t'(act_q);
    end
  end

  assign PWM = act_q;

endmodule

// File: tb/tb_pwm_control.sv
module tb_pwm_control;

  localparam int P  = 100;
  localparam int S  = 20;
  localparam int DB = 4;
`ifdef HOLD_REPEAT_EN
  localparam int RF = 40;
  localparam int RN = 20;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        BTN_UP;
  logic        BTN_DN;
  logic        PWM_OUT;
  logic [18:0] PWM;

  int total = 0;
  int bad   = 0;

  pwm_control #(
    .PERIOD(P), .STEP(S), .DEBOUNCE(DB)
`ifdef HOLD_REPEAT_EN
    , .REPEAT_FIRST(RF), .REPEAT_NEXT(RN)
`endif
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN),
    .PWM_OUT(PWM_OUT), .PWM(PWM)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: dut=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Button i: 0 = up, 1 = down. A level is accepted once the last DB synchronized
  // samples all disagree with the accepted level; the duty follows min/max rules.
  bit m_s1[2], m_s[2], m_acc[2], m_arm[2], m_rep_on[2];
  bit m_hist[2][DB];
  int m_press_cyc[2];
  int m_cyc, m_pend, m_act;
  bit m_out;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s[b] = 0; m_acc[b] = 0; m_arm[b] = 0; m_rep_on[b] = 0;
        m_press_cyc[b] = 0;
        for (int i = 0; i < DB; i++) m_hist[b][i] = 0;
      end
      m_cyc = 0; m_pend = 0; m_act = 0; m_out = 0;
    end else begin
      bit btn[2];
      bit ev[2];
      bit all_diff;
      bit prs;
      int pos;
      btn[0] = BTN_UP;
      btn[1] = BTN_DN;
      for (int b = 0; b < 2; b++) begin
        for (int i = DB - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
        m_hist[b][0] = m_s[b];
        all_diff = 1;
        for (int i = 0; i < DB; i++) if (m_hist[b][i] == m_acc[b]) all_diff = 0;
        prs   = all_diff && m_s[b] && m_arm[b];
        ev[b] = prs;
`ifdef HOLD_REPEAT_EN
        if (m_rep_on[b] && m_acc[b] && (m_cyc - m_press_cyc[b]) >= RF &&
            ((m_cyc - m_press_cyc[b] - RF) % RN) == 0)
          ev[b] = 1;
`endif
        if (prs) begin
          m_press_cyc[b] = m_cyc;
          m_rep_on[b]    = 1;
        end else if (!m_acc[b])
          m_rep_on[b] = 0;
        if (m_cyc >= 2 && !m_s[b] && !m_acc[b]) m_arm[b] = 1;
        if (all_diff) m_acc[b] = m_s[b];
        m_s[b]  = m_s1[b];
        m_s1[b] = btn[b];
      end
      pos   = m_cyc % P;
      m_out = (pos < m_act);
      if (pos == P - 1) m_act = m_pend;
      if (ev[0] && !ev[1])
        m_pend = (m_pend + S > P) ? P : m_pend + S;
      else if (ev[1] && !ev[0])
        m_pend = (m_pend < S) ? 0 : m_pend - S;
      m_cyc++;
    end
  end

  always @(negedge CLK) begin
    chk("pwm_out", int'(PWM_OUT), int'(m_out));
    chk("pwm", int'(PWM), m_act);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive(input int b, input logic v);
    if (b == 0 || b == 2) BTN_UP = v;
    if (b == 1 || b == 2) BTN_DN = v;
  endtask

  task automatic press(input int b, input int hold, input int gap);
    drive(b, 1'b1);
    tick(hold);
    drive(b, 1'b0);
    tick(gap);
  endtask

  // Returns at the negedge right after the edge that loaded a new active duty.
  task automatic to_wrap();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (((m_cyc % P) != 0 || m_cyc == 0) && n < 3 * P);
    if (n >= 3 * P) begin
      total++;
      bad++;
      $display("FAIL wrap_wait: waited=%0d limit=%0d", n, 3 * P);
    end
  endtask

  task automatic high_time(output int hi);
    hi = 0;
    repeat (P) begin
      @(negedge CLK);
      hi += int'(PWM_OUT);
    end
  endtask

  task automatic rst_pulse();
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_pwm", int'(PWM), 0);
    chk("rst_out", int'(PWM_OUT), 0);
    tick(3);
    RST_N = 1'b1;
  endtask

  initial begin
    int hi;
    RST_N  = 1'b0;
    BTN_UP = 1'b1;   // held through reset release
    BTN_DN = 1'b0;
    tick(3);
    chk("reset_pwm", int'(PWM), 0);
    chk("reset_out", int'(PWM_OUT), 0);
    RST_N = 1'b1;
    tick(20);
    BTN_UP = 1'b0;
    tick(10);
    to_wrap();
    chk("held_through_reset", int'(PWM), 0);

    // three clean presses -> 60
    repeat (3) press(0, 8, 8);
    to_wrap();
    chk("three_up_pwm", int'(PWM), 60);
    high_time(hi);
    chk("three_up_high", hi, 60);

    // async reset mid-period with duty 60
    tick(30);
    chk("pre_rst_out", int'(PWM_OUT), 1);
    rst_pulse();
    high_time(hi);
    chk("after_rst_high", hi, 0);

    // glitch and bounce before one stable press
    rst_pulse();
    drive(0, 1'b1); tick(2); drive(0, 1'b0); tick(10);
    repeat (3) begin
      drive(0, 1'b1); tick(3); drive(0, 1'b0); tick(2);
    end
    press(0, 10, 10);
    to_wrap();
    chk("bounce_pwm", int'(PWM), 20);

    // same-cycle up and down leaves duty alone
    press(2, 8, 8);
    to_wrap();
    chk("both_pwm", int'(PWM), 20);

    // press mid-period: no change until wrap
    tick(30);
    press(0, 8, 4);
    while ((m_cyc % P) != P - 1) begin
      chk("mid_hold_pwm", int'(PWM), 20);
      @(negedge CLK);
    end
    to_wrap();
    chk("mid_new_pwm", int'(PWM), 40);
    high_time(hi);
    chk("mid_new_high", hi, 40);

    // saturation at PERIOD, then floor at 0
    rst_pulse();
    repeat (6) press(0, 8, 8);
    to_wrap();
    chk("sat_pwm", int'(PWM), 100);
    high_time(hi);
    chk("sat_high", hi, 100);
    repeat (6) press(1, 8, 8);
    to_wrap();
    chk("floor_pwm", int'(PWM), 0);
    high_time(hi);
    chk("floor_high", hi, 0);

`ifdef HOLD_REPEAT_EN
    // held ~75 cycles: press, +40, +60 -> three events
    rst_pulse();
    press(0, 75, 10);
    to_wrap();
    chk("repeat_pwm", int'(PWM), 60);
`endif

    // randomized traffic against the model
    rst_pulse();
    for (int k = 0; k < 150; k++) begin
      int r, b, hold;
      r = int'($urandom_range(0, 19));
      b = (r < 8) ? 0 : (r < 16) ? 1 : 2;
      hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 90))
                                          : int'($urandom_range(1, 12));
      press(b, hold, int'($urandom_range(1, 12)));
      if (r == 19 && $urandom_range(0, 3) == 0) begin
        @(posedge CLK);
        #($urandom_range(1, 8)) RST_N = 1'b0;
        #1;
        chk("rand_rst_pwm", int'(PWM), 0);
        tick(2);
        RST_N = 1'b1;
      end
    end
    tick(2 * P);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
